// File: rtl/i2s_tx.sv
// I2S master transmitter: one 16-bit mono sample per frame, sent on both slots.
// Single-entry holding buffer absorbs filter strobes; underrun repeats last word.
module i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  output logic        sample_ready,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic [4:0]    bit_cnt;
  logic [31:0]   fsr;
  logic [15:0]   pend;
  logic          pend_valid;
  logic [15:0]   last_word;

  logic          div_wrap;
  logic          fall;
  logic [4:0]    bit_cnt_next;
  logic          load;
  logic [15:0]   word;
  logic          under;
  logic          ovr;
  logic [15:0]   pend_n;
  logic          pend_valid_n;

  assign div_wrap     = (div_cnt == DIV_LAST);
  assign fall         = div_wrap & bclk;
  assign bit_cnt_next = bit_cnt + 5'd1;
  assign load         = fall & (bit_cnt_next == 5'd0);

  // Word selection: a strobe coinciding with the frame load bypasses the buffer.
  always_comb begin
    word         = last_word;
    under        = 1'b0;
    ovr          = 1'b0;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    if (load) begin
      if (sample_valid) begin
        word         = sample_in;
        ovr          = pend_valid;
        pend_valid_n = 1'b0;
      end else if (pend_valid) begin
        word         = pend;
        pend_valid_n = 1'b0;
      end else begin
        under = 1'b1;
      end
    end else if (sample_valid) begin
      pend_n       = sample_in;
      pend_valid_n = 1'b1;
      ovr          = pend_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      bit_cnt     <= 5'd31;
      fsr         <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      last_word   <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= ovr;
      pend        <= pend_n;
      pend_valid  <= pend_valid_n;
      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      // sdata takes the old MSB, giving the one-bit I2S delay after lrclk changes.
      if (fall) begin
        bit_cnt <= bit_cnt_next;
        lrclk   <= bit_cnt_next[4];
        sdata   <= fsr[31];
        if (load) begin
          fsr         <= {word, word};
          last_word   <= word;
          frame_start <= 1'b1;
          underrun    <= under;
        end else begin
          fsr <= {fsr[30:0], 1'b0};
        end
      end
    end
  end

  assign sample_ready = ~pend_valid;
  assign i2s_bclk     = bclk;
  assign i2s_lrclk    = lrclk;
  assign i2s_sdata    = sdata;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: stimulus pushes expected frame words; a monitor deserialises and compares.
module tb_i2s_tx;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        sample_ready;
  logic        frame_start;
  logic        underrun;
  logic        overrun;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .overrun      (overrun),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic        und;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: collects the 32 bits following each frame_start on bclk falls.
  logic        prev_bclk = 1'b0;
  logic        collecting = 1'b0;
  logic        und_seen;
  logic [31:0] shreg;
  logic [31:0] lrv;
  int          nbits;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        collecting = 1'b0;
        prev_bclk  = 1'b0;
      end else begin
        if (overrun) ovr_cnt++;
        if (prev_bclk && !i2s_bclk && collecting) begin
          shreg = {shreg[30:0], i2s_sdata};
          lrv   = {lrv[30:0], i2s_lrclk};
          nbits++;
          if (nbits == 32) begin
            collecting = 1'b0;
            if (sb_q.size() == 0) begin
              check("sb_empty", 32'd0, 32'd1);
            end else begin
              exp_t e;
              e = sb_q.pop_front();
              check("left_word", {16'h0, shreg[31:16]}, {16'h0, e.word});
              check("right_word", {16'h0, shreg[15:0]}, {16'h0, e.word});
              check("underrun_flag", {31'h0, und_seen}, {31'h0, e.und});
              check("lrclk_pattern", lrv, 32'h0001_FFFE);
            end
          end
        end
        prev_bclk = i2s_bclk;
        if (frame_start) begin
          collecting = 1'b1;
          nbits      = 0;
          und_seen   = underrun;
        end
      end
    end
  end

  task automatic push(input logic [15:0] w, input logic u);
    exp_t e;
    e.word = w;
    e.und  = u;
    sb_q.push_back(e);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    if (!frame_start) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic strobe(input logic [15:0] w);
    sample_valid = 1'b1;
    sample_in    = w;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic release_and_check();
    int k;
    reset = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 20);
    check("first_load_clk", k, 2 * CLK_DIV);
    push(16'h0000, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("reset_outputs",
          {25'h0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_ready, frame_start, underrun, overrun},
          32'b0101000);
  endtask

  initial begin
    int n;
    int ovr_base;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Idle: frames carry zero with underrun; frame period and bclk period.
    release_and_check();
    wait_frame(n);
    check("frame_period", n, 256);
    push(16'h0000, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!i2s_bclk && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (i2s_bclk && n < 20);
    do begin @(negedge clk); n++; end while (!i2s_bclk && n < 20);
    check("bclk_period", n, 2 * CLK_DIV);

    // Mid-frame sample goes out next frame.
    repeat (80) @(negedge clk);
    strobe(16'hA5C3);
    check("ready_after_strobe", {31'h0, sample_ready}, 32'd0);
    wait_frame(n);
    push(16'hA5C3, 1'b0);
    @(negedge clk);
    check("ready_after_load", {31'h0, sample_ready}, 32'd1);

    // Single sample repeated for two underrun frames.
    repeat (100) @(negedge clk);
    strobe(16'h1234);
    wait_frame(n);
    push(16'h1234, 1'b0);
    wait_frame(n);
    push(16'h1234, 1'b1);
    wait_frame(n);
    push(16'h1234, 1'b1);

    // Two strobes in one frame: newest kept, one overrun.
    ovr_base = ovr_cnt;
    repeat (50) @(negedge clk);
    strobe(16'h1111);
    repeat (50) @(negedge clk);
    strobe(16'h2222);
    repeat (2) @(negedge clk);
    check("overrun_double_strobe", ovr_cnt - ovr_base, 1);
    wait_frame(n);
    push(16'h2222, 1'b0);

    // Strobe in the frame-load clock, buffer empty.
    ovr_base = ovr_cnt;
    repeat (255) @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 16'h7FFF;
    @(negedge clk);
    sample_valid = 1'b0;
    check("bypass_frame_start", {31'h0, frame_start}, 32'd1);
    push(16'h7FFF, 1'b0);
    repeat (2) @(negedge clk);
    check("bypass_no_overrun", ovr_cnt - ovr_base, 0);

    // Strobe in the frame-load clock while the buffer holds 0001.
    repeat (98) @(negedge clk);
    strobe(16'h0001);
    repeat (154) @(negedge clk);
    ovr_base = ovr_cnt;
    sample_valid = 1'b1;
    sample_in    = 16'h7FFF;
    @(negedge clk);
    sample_valid = 1'b0;
    check("bypass2_frame_start", {31'h0, frame_start}, 32'd1);
    push(16'h7FFF, 1'b0);
    repeat (2) @(negedge clk);
    check("bypass_overrun", ovr_cnt - ovr_base, 1);

    // Reset with bit_cnt at 9: frame at L+0 load, ninth fall at L+72.
    repeat (73) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(negedge clk);
    sb_q.delete();
    release_and_check();
    wait_frame(n);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
